// File: rtl/tk1_spi_target.sv
// SPI mode-0 target: oversamples the host's SPI pins in the clk domain, delivers received
// bytes on an rx valid/ack handshake and shifts transmit bytes out of a one-deep holding buffer.
module tk1_spi_target #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  FILL_BYTE   = 8'hff
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_ss,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_en,
  input  logic [7:0] tx_data,
  input  logic       tx_data_vld,
  output logic       tx_ready,
  output logic       tx_underrun,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   ss_d;
  logic                   sck_d;
  logic                   ss_s;
  logic                   sck_s;
  logic                   mosi_s;
  logic                   ss_fall;
  logic                   sck_rise;
  logic                   sck_fall;

  logic [7:0]             tx_buf;
  logic                   tx_full;
  logic [7:0]             tx_shift;
  logic [6:0]             rx_shift;
  logic [2:0]             bit_cnt;
  logic                   rise_seen;
  logic [7:0]             rx_byte;
  logic                   reload;
  logic [7:0]             reload_byte;

  // NOTE: every register here, including the synchroniser flops, uses <= so each stage
  // samples the previous stage's old value; blocking assignments would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_sync   <= '0;
      sck_sync  <= '0;
      mosi_sync <= '0;
      ss_d      <= 1'b0;
      sck_d     <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      ss_d      <= ss_s;
      sck_d     <= sck_s;
    end
  end

  assign ss_s     = ss_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign ss_fall  = ss_d & ~ss_s;
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = sck_d & ~sck_s;

  // A reload happens once at frame start and on each falling edge that closes a byte;
  // a frame ending (ss_s high) takes priority so the last edge never consumes the buffer.
  assign reload      = (state == LOAD) ||
                       (state == ACTIVE && !ss_s && sck_fall && rise_seen && bit_cnt == 3'd0);
  assign reload_byte = tx_full ? tx_buf : FILL_BYTE;
  assign rx_byte     = {rx_shift, mosi_s};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tx_buf      <= '0;
      tx_full     <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      rise_seen   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;

      // A write can only land while empty, so it never races a reload that drains the buffer.
      if (reload && tx_full) begin
        tx_full <= 1'b0;
      end else if (tx_data_vld && !tx_full) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end

      if (reload) begin
        tx_shift    <= reload_byte;
        tx_underrun <= ~tx_full;
      end

      if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (ss_fall) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          bit_cnt   <= '0;
          rise_seen <= 1'b0;
          state     <= ACTIVE;
        end
        ACTIVE: begin
          if (ss_s) begin
            state <= IDLE;
          end else if (sck_rise) begin
            rx_shift  <= rx_byte[6:0];
            bit_cnt   <= bit_cnt + 3'd1;
            rise_seen <= 1'b1;
            if (bit_cnt == 3'd7) begin
              // An ack in the completion cycle frees the slot for the new byte.
              if (!rx_valid || rx_ack) begin
                rx_data  <= rx_byte;
                rx_valid <= 1'b1;
              end else begin
                rx_overrun <= 1'b1;
              end
            end
          end else if (sck_fall && rise_seen && bit_cnt != 3'd0) begin
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign spi_miso_en = busy & ~ss_s;
  assign spi_miso    = spi_miso_en ? tx_shift[7] : 1'b1;
  assign tx_ready    = ~tx_full;

endmodule

// File: tb/tb_tk1_spi_target.sv
// Self-checking bench for tk1_spi_target: a behavioural SPI host plus queues of expected
// MISO and rx bytes, pulse counters and a reset-in-flight check.
`timescale 1ns/1ps
module tb_tk1_spi_target;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int          HALF        = 80;

  logic       clk;
  logic       reset;
  logic       spi_ss;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_en;
  logic [7:0] tx_data;
  logic       tx_data_vld;
  logic       tx_ready;
  logic       tx_underrun;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_overrun;
  logic       busy;

  tk1_spi_target #(.SYNC_STAGES(SYNC_STAGES), .FILL_BYTE(8'hff)) dut (
    .clk         (clk),
    .reset       (reset),
    .spi_ss      (spi_ss),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_en (spi_miso_en),
    .tx_data     (tx_data),
    .tx_data_vld (tx_data_vld),
    .tx_ready    (tx_ready),
    .tx_underrun (tx_underrun),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ack      (rx_ack),
    .rx_overrun  (rx_overrun),
    .busy        (busy)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] miso_q[$];
  logic [7:0] rx_q[$];

  int underrun_cnt  = 0;
  int overrun_cnt   = 0;
  int extra_rx      = 0;
  int host_rise_cnt = 0;
  int ack_on_rise   = 0;
  int ack_countdown = 0;
  bit ack_auto      = 1'b1;
  bit manual_ack    = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // rx monitor and ack driver; rx_ack as read here is the value that drove the last posedge.
  initial begin
    logic valid_prev;
    logic next_ack;
    logic [7:0] exp;
    valid_prev = 1'b0;
    rx_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_valid && (!valid_prev || rx_ack)) begin
        if (rx_q.size() == 0) begin
          extra_rx++;
        end else begin
          exp = rx_q.pop_front();
          check("rx_data", {24'd0, rx_data}, {24'd0, exp});
        end
      end
      if (tx_underrun) underrun_cnt++;
      if (rx_overrun)  overrun_cnt++;
      valid_prev = rx_valid;
      next_ack = 1'b0;
      if (ack_auto && rx_valid && !rx_ack) next_ack = 1'b1;
      if (manual_ack) begin
        next_ack   = 1'b1;
        manual_ack = 1'b0;
      end
      if (ack_countdown > 0) begin
        ack_countdown--;
        if (ack_countdown == 0) next_ack = 1'b1;
      end
      rx_ack = next_ack;
    end
  end

  // Times an ack so it is high exactly in the cycle the DUT sees the chosen rising edge.
  initial begin
    forever begin
      @(posedge spi_sck);
      if (ack_on_rise != 0 && host_rise_cnt == ack_on_rise) ack_countdown = SYNC_STAGES;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  // Mode-0 host; the last sck fall and ss release share one instant so no trailing reload occurs.
  task automatic host_xfer(input int nbits, input logic [23:0] mosi_word, output logic [23:0] miso_word);
    miso_word     = '0;
    host_rise_cnt = 0;
    spi_mosi      = mosi_word[nbits-1];
    spi_ss        = 1'b0;
    #(HALF);
    for (int i = 0; i < nbits; i++) begin
      miso_word     = {miso_word[22:0], spi_miso};
      host_rise_cnt = i + 1;
      spi_sck       = 1'b1;
      #(HALF);
      spi_sck = 1'b0;
      if (i == nbits - 1) spi_ss = 1'b1;
      else spi_mosi = mosi_word[nbits-2-i];
      #(HALF);
    end
    #(HALF);
  endtask

  task automatic frame(input int nbytes, input logic [23:0] mosi);
    logic [23:0] miso;
    logic [7:0]  exp;
    @(negedge clk);
    #2;
    host_xfer(nbytes * 8, mosi, miso);
    for (int b = nbytes - 1; b >= 0; b--) begin
      exp = (miso_q.size() != 0) ? miso_q.pop_front() : 8'hxx;
      check("miso_byte", {24'd0, miso[b*8 +: 8]}, {24'd0, exp});
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data     = d;
    tx_data_vld = 1'b1;
    @(negedge clk);
    tx_data_vld = 1'b0;
  endtask

  task automatic clear_counts();
    underrun_cnt = 0;
    overrun_cnt  = 0;
  endtask

  task automatic ack_once();
    manual_ack = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string when);
    check({when, "_miso"},     {31'd0, spi_miso},    32'd1);
    check({when, "_miso_en"},  {31'd0, spi_miso_en}, 32'd0);
    check({when, "_tx_ready"}, {31'd0, tx_ready},    32'd1);
    check({when, "_underrun"}, {31'd0, tx_underrun}, 32'd0);
    check({when, "_rx_data"},  {24'd0, rx_data},     32'd0);
    check({when, "_rx_valid"}, {31'd0, rx_valid},    32'd0);
    check({when, "_overrun"},  {31'd0, rx_overrun},  32'd0);
    check({when, "_busy"},     {31'd0, busy},        32'd0);
  endtask

  initial begin
    logic [23:0] dummy;
    reset       = 1'b1;
    spi_ss      = 1'b1;
    spi_sck     = 1'b0;
    spi_mosi    = 1'b0;
    tx_data     = '0;
    tx_data_vld = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Single byte with a preloaded tx byte.
    write_tx(8'h3c);
    check("tx_ready_full", {31'd0, tx_ready}, 32'd0);
    miso_q.push_back(8'h3c);
    rx_q.push_back(8'ha5);
    clear_counts();
    frame(1, 24'h0000a5);
    check("t1_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("t1_underrun", underrun_cnt, 0);
    check("t1_overrun", overrun_cnt, 0);
    check("t1_rx_data", {24'd0, rx_data}, 32'ha5);

    // Two bytes, buffer refilled while the first byte is on the wire.
    write_tx(8'h3c);
    miso_q.push_back(8'h3c);
    miso_q.push_back(8'h55);
    rx_q.push_back(8'h01);
    rx_q.push_back(8'h80);
    clear_counts();
    fork
      frame(2, 24'h000180);
      begin
        #300;
        write_tx(8'h55);
      end
    join
    check("t2_underrun", underrun_cnt, 0);
    check("t2_tx_ready", {31'd0, tx_ready}, 32'd1);

    // Empty buffer: FILL_BYTE at frame start and at the byte boundary.
    miso_q.push_back(8'hff);
    miso_q.push_back(8'hff);
    rx_q.push_back(8'h00);
    rx_q.push_back(8'hff);
    clear_counts();
    frame(2, 24'h0000ff);
    check("t3_underrun", underrun_cnt, 2);

    // Three bytes, no ack: first kept, two dropped.
    ack_auto = 1'b0;
    for (int i = 0; i < 3; i++) miso_q.push_back(8'hff);
    rx_q.push_back(8'h11);
    clear_counts();
    frame(3, 24'h112233);
    check("t4_overrun", overrun_cnt, 2);
    check("t4_underrun", underrun_cnt, 3);
    check("t4_rx_data", {24'd0, rx_data}, 32'h11);
    check("t4_rx_valid", {31'd0, rx_valid}, 32'd1);
    ack_once();
    check("t4_rx_cleared", {31'd0, rx_valid}, 32'd0);

    // Same frame, ack lands in byte 2's completion cycle.
    for (int i = 0; i < 3; i++) miso_q.push_back(8'hff);
    rx_q.push_back(8'h11);
    rx_q.push_back(8'h22);
    ack_on_rise = 16;
    clear_counts();
    frame(3, 24'h112233);
    ack_on_rise = 0;
    check("t4b_overrun", overrun_cnt, 1);
    check("t4b_rx_data", {24'd0, rx_data}, 32'h22);
    check("t4b_rx_valid", {31'd0, rx_valid}, 32'd1);
    ack_once();
    ack_auto = 1'b1;

    // Partial frame of 5 bits, then a full frame; the loaded 8'h96 is lost.
    write_tx(8'h96);
    clear_counts();
    @(negedge clk);
    #2;
    host_xfer(5, 24'h000015, dummy);
    repeat (10) @(negedge clk);
    check("t5_partial_miso", {27'd0, dummy[4:0]}, 32'h12);
    check("t5_partial_valid", {31'd0, rx_valid}, 32'd0);
    write_tx(8'h5a);
    miso_q.push_back(8'h5a);
    rx_q.push_back(8'hc3);
    frame(1, 24'h0000c3);
    check("t5_overrun", overrun_cnt, 0);
    check("t5_underrun", underrun_cnt, 0);
    check("t5_rx_data", {24'd0, rx_data}, 32'hc3);

    // Reset asserted during bit 4 of a frame, with the tx buffer full.
    host_rise_cnt = 0;
    fork
      begin
        @(negedge clk);
        #2;
        host_xfer(8, 24'h0000f0, dummy);
      end
      begin
        wait (host_rise_cnt == 2);
        repeat (5) @(negedge clk);
        write_tx(8'h42);
        wait (host_rise_cnt == 4);
        @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        check("pre_rst_tx_ready", {31'd0, tx_ready}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check_reset_outputs("async");
      end
    join
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    miso_q.push_back(8'hff);
    rx_q.push_back(8'h7e);
    clear_counts();
    frame(1, 24'h00007e);
    check("t6_rx_data", {24'd0, rx_data}, 32'h7e);
    check("t6_underrun", underrun_cnt, 1);

    check("rx_extra", extra_rx, 0);
    check("rx_missing", rx_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
